// File: rtl/beep_gen.sv
// rtl/beep_gen.sv - piezo buzzer driver: programmable-pitch tone bursts with optional repeats
// Single-cycle start requests become square-wave bursts timed by a slow en strobe.
module beep_gen #(
    parameter int HP_W  = 16,
    parameter int DUR_W = 8,
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic [HP_W-1:0]  half_period,
    input  logic [DUR_W-1:0] duration,
    input  logic [REP_W-1:0] repeats,
    output logic             busy,
    output logic             buzz,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t           state;
    logic [HP_W-1:0]  hp;
    logic [HP_W-1:0]  phase_cnt;
    logic [DUR_W-1:0] dur;
    logic [DUR_W-1:0] dur_cnt;
    logic [REP_W-1:0] rep_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hp        <= '0;
            phase_cnt <= '0;
            dur       <= '0;
            dur_cnt   <= '0;
            rep_cnt   <= '0;
            busy      <= 1'b0;
            buzz      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        // A zero-length request completes at once without sounding.
                        if (duration == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ON;
                            busy      <= 1'b1;
                            buzz      <= 1'b0;
                            phase_cnt <= '0;
                            hp        <= (half_period == '0) ? HP_W'(1) : half_period;
                            dur       <= duration;
                            dur_cnt   <= duration;
                            rep_cnt   <= (repeats == '0) ? REP_W'(1) : repeats;
                        end
                    end
                end
                ON: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        buzz      <= 1'b0;
                        phase_cnt <= '0;
                    end else if (en && dur_cnt == DUR_W'(1)) begin
                        buzz      <= 1'b0;
                        phase_cnt <= '0;
                        if (rep_cnt > REP_W'(1)) begin
                            state   <= OFF;
                            dur_cnt <= dur;
                            rep_cnt <= rep_cnt - REP_W'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        if (en) begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        end
                        if (phase_cnt == hp - HP_W'(1)) begin
                            buzz      <= ~buzz;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + HP_W'(1);
                        end
                    end
                end
                OFF: begin
                    buzz      <= 1'b0;
                    phase_cnt <= '0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (en) begin
                        if (dur_cnt == DUR_W'(1)) begin
                            state   <= ON;
                            dur_cnt <= dur;
                        end else begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    buzz  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_gen.sv
// tb/tb_beep_gen.sv - scoreboard bench for beep_gen
// Bursts are summarised (length, rising edges, first high run, long gaps, done) and matched to queued expectations.
module tb_beep_gen;

    localparam int HP_W  = 16;
    localparam int DUR_W = 8;
    localparam int REP_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [HP_W-1:0]  half_period = '0;
    logic [DUR_W-1:0] duration = '0;
    logic [REP_W-1:0] repeats = '0;
    logic             busy;
    logic             buzz;
    logic             done;

    beep_gen #(.HP_W(HP_W), .DUR_W(DUR_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
        .half_period(half_period), .duration(duration), .repeats(repeats),
        .busy(busy), .buzz(buzz), .done(done)
    );

    always #5 clk = ~clk;

    int en_div = 0;
    always @(posedge clk) en_div <= (en_div == 49) ? 0 : en_div + 1;
    assign en = (en_div == 49);

    typedef struct {
        int len;
        int rises;
        int hi;
        int gaps;
        int dn;
    } txn_t;

    txn_t  exp_q[$];
    int    checks = 0;
    int    passed = 0;
    string cur = "init";

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    task automatic expect_txn(input int len, input int rises, input int hi, input int gaps, input int dn);
        txn_t t;
        t.len = len; t.rises = rises; t.hi = hi; t.gaps = gaps; t.dn = dn;
        exp_q.push_back(t);
    endtask

    // start is sampled on the edge right after an en edge, so en falls at ON-cycle 48, 98, 148, ...
    task automatic issue(input int hp, input int dur, input int rep, input bit ab);
        @(negedge clk);
        while (en_div != 49) @(negedge clk);
        half_period = hp[HP_W-1:0];
        duration    = dur[DUR_W-1:0];
        repeats     = rep[REP_W-1:0];
        @(negedge clk);
        start = 1'b1;
        abort = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({cur, ".drain"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    int   m_len, m_rises, m_hi, m_first, m_low, m_gaps;
    logic pb = 1'b0;
    logic pz = 1'b0;

    always @(negedge clk) begin
        int   g_len, g_rises, g_hi, g_gaps, g_dn;
        txn_t e;
        if (busy === 1'b1 && !pb) begin
            m_len = 0; m_rises = 0; m_hi = 0; m_first = 0; m_low = 0; m_gaps = 0;
        end
        if (busy === 1'b1) begin
            m_len++;
            if (buzz === 1'b1) begin
                if (!pz) begin
                    m_rises++;
                    if (m_low >= 40) m_gaps++;
                    m_low = 0;
                end
                m_hi++;
            end else begin
                if (pz && m_first == 0) m_first = m_hi;
                m_hi = 0;
                m_low++;
            end
        end
        if ((pb && busy !== 1'b1) || (done === 1'b1 && !pb)) begin
            if (pb) begin
                g_len = m_len; g_rises = m_rises; g_gaps = m_gaps;
                g_hi  = (m_first != 0) ? m_first : m_hi;
            end else begin
                g_len = 0; g_rises = 0; g_hi = 0; g_gaps = 0;
            end
            g_dn = (done === 1'b1) ? 1 : 0;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL %s.unexpected_txn: got len %0d done %0d, expected no burst", cur, g_len, g_dn);
            end else begin
                e = exp_q.pop_front();
                chk({cur, ".len"},   g_len,   e.len);
                chk({cur, ".rises"}, g_rises, e.rises);
                chk({cur, ".hi"},    g_hi,    e.hi);
                chk({cur, ".gaps"},  g_gaps,  e.gaps);
                chk({cur, ".done"},  g_dn,    e.dn);
            end
        end
        pb = (busy === 1'b1);
        pz = (buzz === 1'b1);
    end

    initial begin
        int n;
        int cnt;

        repeat (3) @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.buzz", int'(buzz), 0);
        chk("reset.done", int'(done), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        cur = "single";
        expect_txn(149, 19, 4, 0, 1);
        issue(4, 3, 1, 1'b0);
        drain();

        cur = "repeats";
        expect_txn(499, 36, 4, 2, 1);
        issue(4, 2, 3, 1'b0);
        drain();

        cur = "hp0";
        expect_txn(49, 24, 1, 0, 1);
        issue(0, 1, 1, 1'b0);
        drain();

        cur = "dur0";
        expect_txn(0, 0, 0, 0, 1);
        issue(4, 0, 1, 1'b0);
        chk("dur0.done_next_cycle", int'(done), 1);
        chk("dur0.busy", int'(busy), 0);
        drain();

        cur = "rep0";
        expect_txn(49, 12, 2, 0, 1);
        issue(2, 1, 0, 1'b0);
        drain();

        cur = "abort_on";
        expect_txn(21, 3, 4, 0, 0);
        issue(4, 3, 1, 1'b0);
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_on.buzz", int'(buzz), 0);
        drain();

        cur = "abort_off";
        expect_txn(71, 6, 4, 0, 0);
        issue(4, 1, 2, 1'b0);
        repeat (70) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_off.busy", int'(busy), 0);
        drain();

        cur = "abort_term";
        expect_txn(49, 6, 4, 0, 0);
        issue(4, 1, 1, 1'b0);
        repeat (48) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain();

        cur = "start_abort_idle";
        issue(4, 1, 1, 1'b1);
        cnt = 0;
        repeat (80) begin
            if (busy !== 1'b0) cnt++;
            @(negedge clk);
        end
        chk("start_abort_idle.busy_cycles", cnt, 0);

        cur = "start_busy";
        expect_txn(299, 24, 4, 1, 1);
        issue(4, 2, 2, 1'b0);
        repeat (30) @(negedge clk);
        half_period = 16'd1;
        duration    = 8'd1;
        repeats     = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        cur = "rst_mid";
        expect_txn(5, 1, 1, 0, 0);
        issue(4, 3, 1, 1'b0);
        n = 0;
        while (buzz !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid.buzz_high_seen", int'(buzz === 1'b1), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.buzz", int'(buzz), 0);
        chk("rst_mid.busy", int'(busy), 0);
        chk("rst_mid.done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (120) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) cnt++;
        end
        chk("rst_mid.idle_after_release", cnt, 0);
        drain();

        chk("final.queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/beep_gen.md
Name: beep_gen

Overview:
- Output-side counterpart of the button debouncer: the debouncer cleans a raw physical input into a stable level, while this block turns single-cycle internal game events (food eaten, game over) into a physical square-wave drive for a piezo buzzer.
- It generates a tone burst of programmable pitch and duration, optionally repeated with equal-length silent gaps.
- Timing uses the same slow `en` strobe style (intended ~1 ms tick) for durations.
- The pitch counter runs on every clk.

Parameters:
- HP_W, 16, width of half_period (tone half-period in clk cycles)
- DUR_W, 8, width of duration (tone/gap length in en ticks)
- REP_W, 3, width of repeats (number of beeps per request)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high; all state clears immediately on assertion
- en  input  1  slow timing strobe, one-cycle pulse (~1 ms period)
- start  input  1  one-cycle request pulse; sampled only in IDLE
- abort  input  1  one-cycle pulse; cancels any burst in progress
- half_period  input  HP_W  tone half-period in clk cycles; latched on accepted start
- duration  input  DUR_W  tone length, and gap length, in en ticks; latched on accepted start
- repeats  input  REP_W  beeps per request; latched on accepted start
- busy  output  1  high from the cycle after an accepted start until return to IDLE
- buzz  output  1  square-wave drive to the buzzer
- done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: state=IDLE, buzz=0, busy=0, done=0, all counters and latched fields 0.
- States: IDLE, ON, OFF. All outputs are registered.
- Latching rules on an accepted start:
  - half_period=0 is latched as 1.
  - repeats=0 is latched as 1.
  - duration=0 means no tone at all: the next cycle has done=1, state stays IDLE, busy stays 0.
- IDLE, start=1, abort=0, duration!=0: on the next cycle state=ON, busy=1, buzz=0, phase_cnt=0, dur_cnt=duration, rep_cnt=repeats.
- ON, pitch generation:
  - phase_cnt increments every clk.
  - When phase_cnt==hp-1: buzz toggles and phase_cnt returns to 0.
  - Resulting period is 2*hp clk cycles. The first rising edge of buzz occurs hp cycles after entering ON.
- ON, duration counting: dur_cnt decrements on each en.
  - On en with dur_cnt==1 and rep_cnt>1: go to OFF, buzz=0, dur_cnt=duration, rep_cnt decrements.
  - On en with dur_cnt==1 and rep_cnt==1: go to IDLE, buzz=0, busy=0, done=1 for exactly one cycle.
- OFF: buzz held at 0, phase_cnt held at 0, dur_cnt decrements on each en. On en with dur_cnt==1: go to ON, dur_cnt=duration.
- Duration accuracy: en is asynchronous to start, so a tone lasts between (d-1) and d en periods. A gap lasts exactly d en periods.
- abort: in ON or OFF, the next cycle has state=IDLE, buzz=0, busy=0, and no done pulse. In IDLE, abort has no effect.
- Simultaneous events:
  - abort and start in the same IDLE cycle: abort wins, the request is dropped.
  - abort and a terminal en in the same cycle: abort wins, no done pulse.
- start while busy=1 is ignored; no queueing.
- Inputs are not re-sampled mid-burst. Changing half_period, duration or repeats during busy has no effect.
- rst asserted mid-burst: buzz=0 and busy=0 immediately (asynchronously), no done pulse.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-tone with buzz=1.
  - Required: buzz, busy and done are 0 in the same cycle; after release the block stays IDLE with no spurious done.
- Single beep:
  - Stimulus: half_period=4, duration=3, repeats=1, en every 50 clk.
  - Required: busy rises 1 cycle after start; buzz toggles every 4 clk (period 8); after the third en post-start, buzz=0 and done=1 for one cycle.
- Repeats:
  - Stimulus: repeats=3, duration=2.
  - Required: exactly 3 tone bursts separated by 2 gaps of 2 en periods each, buzz=0 during gaps, a single done at the end.
- Degenerate inputs:
  - half_period=0: buzz toggles every clk.
  - duration=0: done pulses 1 cycle after start, busy never asserts, buzz stays 0.
  - repeats=0: behaves as repeats=1.
- Abort:
  - Abort in ON: next cycle IDLE, buzz=0, no done.
  - Abort in OFF: same response.
  - Abort coincident with the terminal en: no done.
  - start+abort together in IDLE: busy stays 0.
- Start while busy:
  - Stimulus: a second start mid-burst with a different half_period.
  - Required: pitch is unchanged, the burst count is unchanged, and only one done pulse occurs.
